// File: rtl/alu16_issue_stage_pkg.sv
// Shared definitions for the ALU16 issue stage.
//   - ALU16 op encodings (0..11; 12..15 are outside the ALU16 op set)
//   - issue FSM state codes
//   - command word layout {op[3:0], dir, a[DATA_W-1:0], b[DATA_W-1:0]}
//   - decode helpers used when a command is loaded into the ALU16 registers
package alu16_issue_stage_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_ASH = 4'd3;
  localparam logic [3:0] OP_LSH = 4'd4;
  localparam logic [3:0] OP_ROL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_NOT = 4'd10;
  localparam logic [3:0] OP_XOR = 4'd11;

  localparam int OP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of one queued command word for a given operand width.
  function automatic int cmd_w(input int data_w);
    return OP_W + 1 + 2 * data_w;
  endfunction

  function automatic logic dec_sub(input logic [3:0] op);
    return (op == OP_SUB);
  endfunction

  // The direction bit only steers the shifter for the three shift ops.
  function automatic logic dec_shift_dir(input logic [3:0] op, input logic dir);
    return ((op == OP_SHL) || (op == OP_ASH) || (op == OP_LSH)) ? dir : 1'b0;
  endfunction

  // Rotator direction is implied by the op itself: ROL=1, ROR (and all others)=0.
  function automatic logic dec_rot_dir(input logic [3:0] op);
    return (op == OP_ROL);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op > OP_XOR);
  endfunction

endpackage

// File: rtl/alu16_cmd_fifo.sv
// Synchronous command FIFO for the ALU16 issue stage.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_din       write strobe and command word (ignored when full)
//   i_pop, o_dout       read strobe (ignored when empty) and head-of-queue word
//   o_full, o_empty     occupancy flags
//   o_level             number of queued entries, 0..FIFO_DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module alu16_cmd_fifo
  import alu16_issue_stage_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic [cmd_w(DATA_W)-1:0]      i_din,
  input  logic                          i_pop,
  output logic [cmd_w(DATA_W)-1:0]      o_dout,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int CMD_W = cmd_w(DATA_W);
  localparam int AW    = $clog2(FIFO_DEPTH);

  logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/alu16_issue_stage.sv
// Issue stage in front of the combinational ALU16.
// Commands arrive on a valid/ready port, queue in alu16_cmd_fifo, are issued
// one at a time on registered alu_* outputs, and the ALU16 result/cc is
// captured and returned in order on a valid/ready result port.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_dir, cmd_a, cmd_b   command fields
//   alu_valA/valB/aluop/sub/shift_Dir/rot_Dir   registered ALU16 controls
//   alu_result, alu_cc              combinational ALU16 outputs
//   res_valid/res_ready             result handshake
//   res_data, res_cc, res_err       captured result, cc, illegal-op flag
//   fifo_level                      queued command count
// Build option: define ALU16_ISSUE_ILLEGAL_OP_EN to intercept ops 12..15 and
// return res_data=0, res_cc=0, res_err=1 for them instead of issuing them.
module alu16_issue_stage
  import alu16_issue_stage_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd_op,
  input  logic                         cmd_dir,
  input  logic [DATA_W-1:0]            cmd_a,
  input  logic [DATA_W-1:0]            cmd_b,
  output logic [DATA_W-1:0]            alu_valA,
  output logic [DATA_W-1:0]            alu_valB,
  output logic [3:0]                   alu_aluop,
  output logic                         alu_sub,
  output logic                         alu_shift_Dir,
  output logic                         alu_rot_Dir,
  input  logic [DATA_W-1:0]            alu_result,
  input  logic [3:0]                   alu_cc,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [DATA_W-1:0]            res_data,
  output logic [3:0]                   res_cc,
  output logic                         res_err,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int CMD_W = cmd_w(DATA_W);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_full;
  logic                w_empty;
  logic [CMD_W-1:0]    w_head;
  logic [3:0]          w_head_op;
  logic                w_head_dir;
  logic [DATA_W-1:0]   w_head_a;
  logic [DATA_W-1:0]   w_head_b;
  logic                w_head_illegal;
  logic                w_pop;
  logic                w_load;
  logic                w_err_load;
  logic                w_capture;
  logic                w_release;

  logic [DATA_W-1:0]   r_alu_valA;
  logic [DATA_W-1:0]   r_alu_valB;
  logic [3:0]          r_alu_aluop;
  logic                r_alu_sub;
  logic                r_alu_shift_dir;
  logic                r_alu_rot_dir;
  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_data;
  logic [3:0]          r_res_cc;

  // ---- command queue ----
  alu16_cmd_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cmd_valid),
    .i_din   ({cmd_op, cmd_dir, cmd_a, cmd_b}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign cmd_ready  = !w_full;
  assign w_head_op  = w_head[CMD_W-1 -: OP_W];
  assign w_head_dir = w_head[2*DATA_W];
  assign w_head_a   = w_head[2*DATA_W-1 -: DATA_W];
  assign w_head_b   = w_head[DATA_W-1:0];

`ifdef ALU16_ISSUE_ILLEGAL_OP_EN
  assign w_head_illegal = is_illegal(w_head_op);
`else
  assign w_head_illegal = 1'b0;
`endif

  // ---- issue FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---- issue FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty) w_state_nxt = w_head_illegal ? ST_DONE : ST_EXEC;
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (res_ready) begin
          if (w_empty)             w_state_nxt = ST_IDLE;
          else if (w_head_illegal) w_state_nxt = ST_DONE;
          else                     w_state_nxt = ST_EXEC;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- issue FSM: control strobes ----
  // A handed-off result always drops res_valid, even when the next command
  // issues in the same edge, so no result is ever presented twice.
  always_comb begin
    w_pop      = 1'b0;
    w_capture  = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = !w_empty;
      ST_EXEC: w_capture = 1'b1;
      ST_DONE: begin
        w_release = res_ready;
        w_pop     = res_ready && !w_empty;
      end
      default: ;
    endcase
    w_load     = w_pop && !w_head_illegal;
    w_err_load = w_pop && w_head_illegal;
  end

  // ---- issue registers (hold between commands) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_valA      <= '0;
      r_alu_valB      <= '0;
      r_alu_aluop     <= '0;
      r_alu_sub       <= 1'b0;
      r_alu_shift_dir <= 1'b0;
      r_alu_rot_dir   <= 1'b0;
    end else if (w_load) begin
      r_alu_valA      <= w_head_a;
      r_alu_valB      <= w_head_b;
      r_alu_aluop     <= w_head_op;
      r_alu_sub       <= dec_sub(w_head_op);
      r_alu_shift_dir <= dec_shift_dir(w_head_op, w_head_dir);
      r_alu_rot_dir   <= dec_rot_dir(w_head_op);
    end
  end

  // ---- result capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_cc    <= '0;
    end else begin
      if (w_capture || w_err_load) r_res_valid <= 1'b1;
      else if (w_release)          r_res_valid <= 1'b0;
      if (w_capture) begin
        r_res_data <= alu_result;
        r_res_cc   <= alu_cc;
      end else if (w_err_load) begin
        r_res_data <= '0;
        r_res_cc   <= '0;
      end
    end
  end

`ifdef ALU16_ISSUE_ILLEGAL_OP_EN
  logic r_res_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_res_err <= 1'b0;
    else if (w_err_load) r_res_err <= 1'b1;
    else if (w_capture)  r_res_err <= 1'b0;
  end
  assign res_err = r_res_err;
`else
  assign res_err = 1'b0;
`endif

  assign alu_valA      = r_alu_valA;
  assign alu_valB      = r_alu_valB;
  assign alu_aluop     = r_alu_aluop;
  assign alu_sub       = r_alu_sub;
  assign alu_shift_Dir = r_alu_shift_dir;
  assign alu_rot_Dir   = r_alu_rot_dir;
  assign res_valid     = r_res_valid;
  assign res_data      = r_res_data;
  assign res_cc        = r_res_cc;

endmodule
